// File: rtl/pon_burst_pkg.sv
// Shared types and helpers for the PON upstream burst PRBS generator.
// Holds the burst FSM state type, the PRBS order to feedback-tap lookup
// and the limits used to reject illegal parameter combinations.
package pon_burst_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    DELIM,
    PAYLOAD,
    GAP
  } burst_state_e;

  localparam int DATA_W_MIN  = 8;
  localparam int DATA_W_MAX  = 128;
  localparam int DATA_W_STEP = 8;

  // Second tap of the x^N + x^M + 1 polynomial; 0 flags an unsupported order.
  function automatic int prbs_tap(input int order);
    int tap;
    case (order)
      7:       tap = 6;
      15:      tap = 14;
      23:      tap = 18;
      31:      tap = 28;
      default: tap = 0;
    endcase
    return tap;
  endfunction

  function automatic bit prbs_order_legal(input int order);
    return prbs_tap(order) != 0;
  endfunction

endpackage

// File: rtl/prbs_word_lfsr.sv
// Parallel Fibonacci LFSR producing DATA_W PRBS bits per step.
// word_o is the next DATA_W bits of the sequence (MSB is the earliest bit);
// step_i consumes them, load_i restores the all-ones seed.
module prbs_word_lfsr
  import pon_burst_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int PRBS_ORDER = 31
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              step_i,
  input  logic              load_i,
  output logic [DATA_W-1:0] word_o
);

  localparam int TAP     = prbs_tap(PRBS_ORDER);
  localparam int TAP_IDX = (TAP > 0) ? TAP - 1 : 0;

  logic [PRBS_ORDER-1:0] state_q;
  logic [PRBS_ORDER-1:0] state_d;
  logic [PRBS_ORDER-1:0] walk;
  logic                  fb;

  // Unroll DATA_W serial shifts: each new bit is the XOR of the two taps.
  always_comb begin
    walk   = state_q;
    fb     = 1'b0;
    word_o = '0;
    for (int i = 0; i < DATA_W; i++) begin
      fb                 = walk[PRBS_ORDER-1] ^ walk[TAP_IDX];
      word_o[DATA_W-1-i] = fb;
      walk               = {walk[PRBS_ORDER-2:0], fb};
    end
    state_d = walk;
  end

  // Seed register: all ones out of reset or on reload, advance only when stepped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= '1;
    end else if (load_i) begin
      state_q <= '1;
    end else if (step_i) begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/pon_burst_prbs_gen.sv
// PON upstream burst generator: preamble words, one delimiter, a PRBS payload,
// then idle until the burst period expires. All stream outputs are registered.
// Build option: define PON_PRBS_RESEED_EN to reload the PRBS seed at every
// burst start (identical payload per burst); otherwise the sequence runs on.
module pon_burst_prbs_gen
  import pon_burst_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 32,
  parameter int PRBS_ORDER = 31
) (
  input  logic                tx_axis_usrclk,
  input  logic                reset_in,
  input  logic                enable,
  input  logic [CNT_W-1:0]    preamble_length,
  input  logic [CNT_W-1:0]    burst_length,
  input  logic [CNT_W-1:0]    burst_period,
  input  logic [DATA_W-1:0]   preamble,
  input  logic [DATA_W-1:0]   delimiter,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  output logic                m_axis_tuser,
  output logic [DATA_W/8-1:0] m_axis_tkeep,
  output logic [CNT_W-1:0]    burst_count,
  output logic                overrun,
  output logic                cfg_err
);

  if (!((DATA_W >= DATA_W_MIN) && (DATA_W <= DATA_W_MAX) &&
        (DATA_W % DATA_W_STEP == 0) && prbs_order_legal(PRBS_ORDER))) begin : g_bad_params
    $error("pon_burst_prbs_gen: illegal DATA_W or PRBS_ORDER");
  end

`ifdef PON_PRBS_RESEED_EN
  localparam bit RESEED = 1'b1;
`else
  localparam bit RESEED = 1'b0;
`endif

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  burst_state_e        state_q, state_d;
  logic [CNT_W-1:0]    preLen_q, preLen_d;
  logic [CNT_W-1:0]    burstLen_q, burstLen_d;
  logic [CNT_W-1:0]    period_q, period_d;
  logic [DATA_W-1:0]   preWord_q, preWord_d;
  logic [DATA_W-1:0]   delimWord_q, delimWord_d;
  logic [CNT_W-1:0]    wordCnt_q, wordCnt_d;
  logic [CNT_W-1:0]    periodCnt_q, periodCnt_d;
  logic [DATA_W-1:0]   tdata_q, tdata_d;
  logic                tvalid_q, tvalid_d;
  logic                tlast_q, tlast_d;
  logic                tuser_q, tuser_d;
  logic [DATA_W/8-1:0] tkeep_q, tkeep_d;
  logic [CNT_W-1:0]    burstCount_q, burstCount_d;
  logic                overrun_q, overrun_d;
  logic                cfgErr_q, cfgErr_d;

  logic                handshake;
  logic                periodReached;
  logic                startBurst;
  logic                lfsrStep;
  logic                lfsrLoad;
  logic [DATA_W-1:0]   prbsWord;

  assign handshake     = tvalid_q & m_axis_tready;
  // True once the counter sits at burst_period-1 (or beyond, when saturated).
  assign periodReached = (({1'b0, periodCnt_q} + {{CNT_W{1'b0}}, 1'b1}) >= {1'b0, period_q});
  assign lfsrLoad      = startBurst & RESEED;

  prbs_word_lfsr #(
    .DATA_W     (DATA_W),
    .PRBS_ORDER (PRBS_ORDER)
  ) u_lfsr (
    .clk_i  (tx_axis_usrclk),
    .rst_i  (reset_in),
    .step_i (lfsrStep),
    .load_i (lfsrLoad),
    .word_o (prbsWord)
  );

  // Burst sequencing: word advance on handshake, period timing, status flags.
  always_comb begin
    state_d      = state_q;
    preLen_d     = preLen_q;
    burstLen_d   = burstLen_q;
    period_d     = period_q;
    preWord_d    = preWord_q;
    delimWord_d  = delimWord_q;
    wordCnt_d    = wordCnt_q;
    periodCnt_d  = periodCnt_q;
    tdata_d      = tdata_q;
    tvalid_d     = tvalid_q;
    tlast_d      = tlast_q;
    tuser_d      = tuser_q;
    tkeep_d      = tkeep_q;
    burstCount_d = burstCount_q;
    overrun_d    = overrun_q;
    cfgErr_d     = cfgErr_q;
    startBurst   = 1'b0;
    lfsrStep     = 1'b0;

    if ((state_q != IDLE) && (periodCnt_q != period_q)) begin
      periodCnt_d = periodCnt_q + ONE;
    end

    case (state_q)
      IDLE: begin
        if (enable) begin
          if (burst_length != '0) begin
            startBurst = 1'b1;
          end else begin
            cfgErr_d = 1'b1;
          end
        end
      end
      PREAMBLE: begin
        if (handshake) begin
          tuser_d = 1'b0;
          if (wordCnt_q == preLen_q - ONE) begin
            state_d   = DELIM;
            tdata_d   = delimWord_q;
            wordCnt_d = '0;
          end else begin
            wordCnt_d = wordCnt_q + ONE;
          end
        end
      end
      DELIM: begin
        if (handshake) begin
          state_d   = PAYLOAD;
          tuser_d   = 1'b0;
          tdata_d   = prbsWord;
          lfsrStep  = 1'b1;
          tlast_d   = (burstLen_q == ONE);
          wordCnt_d = '0;
        end
      end
      PAYLOAD: begin
        if (handshake) begin
          tuser_d = 1'b0;
          if (tlast_q) begin
            state_d      = GAP;
            tvalid_d     = 1'b0;
            tlast_d      = 1'b0;
            tkeep_d      = '0;
            tdata_d      = '0;
            burstCount_d = burstCount_q + ONE;
            if (periodReached) begin
              overrun_d = 1'b1;
            end
          end else begin
            tdata_d   = prbsWord;
            lfsrStep  = 1'b1;
            wordCnt_d = wordCnt_q + ONE;
            tlast_d   = ((wordCnt_q + ONE) == (burstLen_q - ONE));
          end
        end
      end
      GAP: begin
        if (periodReached) begin
          if (enable && (burst_length != '0)) begin
            startBurst = 1'b1;
          end else begin
            state_d = IDLE;
            if (enable) begin
              cfgErr_d = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (startBurst) begin
      preLen_d    = preamble_length;
      burstLen_d  = burst_length;
      period_d    = burst_period;
      preWord_d   = preamble;
      delimWord_d = delimiter;
      periodCnt_d = '0;
      wordCnt_d   = '0;
      state_d     = (preamble_length != '0) ? PREAMBLE : DELIM;
      tdata_d     = (preamble_length != '0) ? preamble : delimiter;
      tvalid_d    = 1'b1;
      tuser_d     = 1'b1;
      tlast_d     = 1'b0;
      tkeep_d     = '1;
      cfgErr_d    = 1'b0;
    end
  end

  // State and output registers; reset drops every output to zero at once.
  always_ff @(posedge tx_axis_usrclk or posedge reset_in) begin
    if (reset_in) begin
      state_q      <= IDLE;
      preLen_q     <= '0;
      burstLen_q   <= '0;
      period_q     <= '0;
      preWord_q    <= '0;
      delimWord_q  <= '0;
      wordCnt_q    <= '0;
      periodCnt_q  <= '0;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tuser_q      <= 1'b0;
      tkeep_q      <= '0;
      burstCount_q <= '0;
      overrun_q    <= 1'b0;
      cfgErr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      preLen_q     <= preLen_d;
      burstLen_q   <= burstLen_d;
      period_q     <= period_d;
      preWord_q    <= preWord_d;
      delimWord_q  <= delimWord_d;
      wordCnt_q    <= wordCnt_d;
      periodCnt_q  <= periodCnt_d;
      tdata_q      <= tdata_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      tuser_q      <= tuser_d;
      tkeep_q      <= tkeep_d;
      burstCount_q <= burstCount_d;
      overrun_q    <= overrun_d;
      cfgErr_q     <= cfgErr_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tkeep  = tkeep_q;
  assign burst_count   = burstCount_q;
  assign overrun       = overrun_q;
  assign cfg_err       = cfgErr_q;

endmodule

// File: tb/tb_pon_burst_prbs_gen.sv
// Self-checking bench for pon_burst_prbs_gen: a 32-bit/PRBS31 instance driven
// from a table of burst configurations plus corner-case sequences, and a
// 64-bit/PRBS7 instance for the wide-word and seeding behaviour.
// Honours PON_PRBS_RESEED_EN when computing expected payloads.
`timescale 1ns/1ps
module tb_pon_burst_prbs_gen;

  localparam logic [31:0] PRE32 = 32'h05560556;
  localparam logic [31:0] DEL32 = 32'hB2C50FA1;
  localparam logic [63:0] PRE64 = 64'h0556055605560556;
  localparam logic [63:0] DEL64 = 64'hB2C50FA1B2C50FA1;

  typedef struct packed {
    logic [31:0] data;
    logic        user;
    logic        last;
  } word32_t;

  typedef struct packed {
    logic [63:0] data;
    logic        user;
    logic        last;
  } word64_t;

  typedef struct {
    int preN;
    int burstN;
    int periodN;
    bit toggle;
    bit expOverrun;
    int expSpacing;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;

  logic        enable;
  logic [31:0] preLen, burstLen, period;
  logic [31:0] tdata;
  logic        tvalid, tready, tlast, tuser;
  logic [3:0]  tkeep;
  logic [31:0] burstCount;
  logic        overrun, cfgErr;

  logic        en64;
  logic [63:0] tdata64;
  logic        tvalid64, tready64, tlast64, tuser64;
  logic [7:0]  tkeep64;
  logic [31:0] burstCount64;
  logic        overrun64, cfgErr64;

  int          checkCount = 0;
  int          failCount  = 0;
  int          cycleIdx   = 0;
  bit          toggleReady;
  bit          prevStall;
  bit          prevUserValid;
  logic [31:0] prevData;
  logic        prevUser, prevLast;
  int          startCycles[$];
  logic [31:0] bcAtSecond;
  word32_t     expQ[$];
  word64_t     exp64[$];
  bit          hist31[$];
  bit          hist7[$];
  vec_t        vecs[6];

  always #5 clk = ~clk;

  pon_burst_prbs_gen #(.DATA_W(32), .CNT_W(32), .PRBS_ORDER(31)) u_dut (
    .tx_axis_usrclk (clk),
    .reset_in       (rst),
    .enable         (enable),
    .preamble_length(preLen),
    .burst_length   (burstLen),
    .burst_period   (period),
    .preamble       (PRE32),
    .delimiter      (DEL32),
    .m_axis_tdata   (tdata),
    .m_axis_tvalid  (tvalid),
    .m_axis_tready  (tready),
    .m_axis_tlast   (tlast),
    .m_axis_tuser   (tuser),
    .m_axis_tkeep   (tkeep),
    .burst_count    (burstCount),
    .overrun        (overrun),
    .cfg_err        (cfgErr)
  );

  pon_burst_prbs_gen #(.DATA_W(64), .CNT_W(32), .PRBS_ORDER(7)) u_dut64 (
    .tx_axis_usrclk (clk),
    .reset_in       (rst),
    .enable         (en64),
    .preamble_length(32'd1),
    .burst_length   (32'd3),
    .burst_period   (32'd12),
    .preamble       (PRE64),
    .delimiter      (DEL64),
    .m_axis_tdata   (tdata64),
    .m_axis_tvalid  (tvalid64),
    .m_axis_tready  (tready64),
    .m_axis_tlast   (tlast64),
    .m_axis_tuser   (tuser64),
    .m_axis_tkeep   (tkeep64),
    .burst_count    (burstCount64),
    .overrun        (overrun64),
    .cfg_err        (cfgErr64)
  );

  task automatic checkVal(input string name, input logic [127:0] act, input logic [127:0] exp);
    checkCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sequence model: b[n] = b[n-N] ^ b[n-M], history starts as all ones.
  task automatic modelReset();
    hist31.delete();
    hist7.delete();
    repeat (31) hist31.push_back(1'b1);
    repeat (7) hist7.push_back(1'b1);
  endtask

  task automatic modelWord31(output logic [31:0] w);
    bit nb;
    for (int i = 0; i < 32; i++) begin
      nb = hist31[0] ^ hist31[3];
      w[31-i] = nb;
      void'(hist31.pop_front());
      hist31.push_back(nb);
    end
  endtask

  task automatic modelWord7(output logic [63:0] w);
    bit nb;
    for (int i = 0; i < 64; i++) begin
      nb = hist7[0] ^ hist7[1];
      w[63-i] = nb;
      void'(hist7.pop_front());
      hist7.push_back(nb);
    end
  endtask

  task automatic pushBurst32(input int preN, input int burstN);
    logic [31:0] w;
`ifdef PON_PRBS_RESEED_EN
    hist31.delete();
    repeat (31) hist31.push_back(1'b1);
`endif
    for (int i = 0; i < preN; i++) expQ.push_back('{PRE32, i == 0, 1'b0});
    expQ.push_back('{DEL32, preN == 0, 1'b0});
    for (int j = 0; j < burstN; j++) begin
      modelWord31(w);
      expQ.push_back('{w, 1'b0, j == burstN - 1});
    end
  endtask

  task automatic pushBurst64(input int preN, input int burstN);
    logic [63:0] w;
`ifdef PON_PRBS_RESEED_EN
    hist7.delete();
    repeat (7) hist7.push_back(1'b1);
`endif
    for (int i = 0; i < preN; i++) exp64.push_back('{PRE64, i == 0, 1'b0});
    exp64.push_back('{DEL64, preN == 0, 1'b0});
    for (int j = 0; j < burstN; j++) begin
      modelWord7(w);
      exp64.push_back('{w, 1'b0, j == burstN - 1});
    end
  endtask

  // Called on the falling edge: scoreboard pop on handshake, stall stability, burst starts.
  task automatic checkOutput();
    word32_t e;
    if (tvalid) checkVal("tkeep", tkeep, 4'hF);
    if (prevStall) checkVal("stall_hold", {tvalid, tdata, tuser, tlast}, {1'b1, prevData, prevUser, prevLast});
    if (tvalid && tuser && !prevUserValid) begin
      startCycles.push_back(cycleIdx);
      if (startCycles.size() == 2) bcAtSecond = burstCount;
    end
    if (tvalid && tready) begin
      checkVal("queue_nonempty", expQ.size() != 0, 1);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkVal("word", {tdata, tuser, tlast}, {e.data, e.user, e.last});
      end
    end
    prevStall     = tvalid && !tready;
    prevUserValid = tvalid && tuser;
    prevData      = tdata;
    prevUser      = tuser;
    prevLast      = tlast;
  endtask

  task automatic stepCycle();
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
    cycleIdx++;
    if (toggleReady) tready = ~tready;
  endtask

  task automatic doReset();
    rst = 1'b1;
    enable = 1'b0;
    en64 = 1'b0;
    tready = 1'b1;
    tready64 = 1'b1;
    toggleReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    expQ.delete();
    exp64.delete();
    startCycles.delete();
    modelReset();
    prevStall = 1'b0;
    prevUserValid = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    preLen = 32'(v.preN);
    burstLen = 32'(v.burstN);
    period = 32'(v.periodN);
    toggleReady = v.toggle;
    tready = 1'b1;
    enable = 1'b1;
    pushBurst32(v.preN, v.burstN);
    pushBurst32(v.preN, v.burstN);
  endtask

  // Runs until two bursts have been seen and the scoreboard is empty.
  task automatic runBursts(input int newPeriod);
    for (int c = 0; c < 400; c++) begin
      if (expQ.size() == 0 && startCycles.size() >= 2) break;
      stepCycle();
      if (newPeriod != 0 && startCycles.size() >= 1) period = 32'(newPeriod);
      if (startCycles.size() >= 2) enable = 1'b0;
    end
    repeat (2) stepCycle();
    checkVal("drain", expQ.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int spacing;
    int starts64;
    word64_t e64;

    vecs[0] = '{2, 4, 20, 1'b0, 1'b0, 20};
    vecs[1] = '{2, 4, 20, 1'b1, 1'b0, 20};
    vecs[2] = '{2, 4, 5,  1'b0, 1'b1, 8};
    vecs[3] = '{0, 1, 3,  1'b0, 1'b0, 3};
    vecs[4] = '{0, 3, 4,  1'b0, 1'b1, 5};
    vecs[5] = '{1, 2, 5,  1'b0, 1'b0, 5};

    preLen = 32'd0;
    burstLen = 32'd0;
    period = 32'd0;
    rst = 1'b1;
    enable = 1'b0;
    en64 = 1'b0;
    tready = 1'b1;
    tready64 = 1'b1;
    #1;
    checkVal("rst_tdata", tdata, 0);
    checkVal("rst_tvalid", tvalid, 0);
    checkVal("rst_tlast", tlast, 0);
    checkVal("rst_tuser", tuser, 0);
    checkVal("rst_tkeep", tkeep, 0);
    checkVal("rst_burst_count", burstCount, 0);
    checkVal("rst_overrun", overrun, 0);
    checkVal("rst_cfg_err", cfgErr, 0);
    checkVal("rst_tvalid64", tvalid64, 0);

    for (int i = 0; i < 6; i++) begin
      doReset();
      applyStimulus(vecs[i]);
      runBursts(0);
      spacing = (startCycles.size() >= 2) ? startCycles[1] - startCycles[0] : -1;
      checkVal($sformatf("v%0d_spacing", i), spacing, vecs[i].expSpacing);
      checkVal($sformatf("v%0d_overrun", i), overrun, vecs[i].expOverrun);
      checkVal($sformatf("v%0d_count_mid", i), bcAtSecond, 1);
      checkVal($sformatf("v%0d_count_end", i), burstCount, 2);
      checkVal($sformatf("v%0d_idle", i), tvalid, 0);
    end

    // Overrun is sticky, and a period change mid-burst waits for the next start.
    doReset();
    preLen = 32'd2;
    burstLen = 32'd4;
    period = 32'd5;
    enable = 1'b1;
    pushBurst32(2, 4);
    pushBurst32(2, 4);
    runBursts(30);
    spacing = (startCycles.size() >= 2) ? startCycles[1] - startCycles[0] : -1;
    checkVal("latched_period_spacing", spacing, 8);
    checkVal("overrun_sticky", overrun, 1);

    // Zero-length burst is refused, then a one-word burst clears the error.
    doReset();
    preLen = 32'd0;
    burstLen = 32'd0;
    period = 32'd10;
    enable = 1'b1;
    repeat (3) stepCycle();
    checkVal("cfg_err_set", cfgErr, 1);
    checkVal("cfg_err_no_valid", tvalid, 0);
    burstLen = 32'd1;
    pushBurst32(0, 1);
    stepCycle();
    checkVal("cfg_err_clear", cfgErr, 0);
    checkVal("cfg_err_start_valid", tvalid, 1);
    checkVal("cfg_err_start_user", tuser, 1);
    enable = 1'b0;
    for (int c = 0; c < 50 && expQ.size() != 0; c++) stepCycle();
    checkVal("cfg_err_drain", expQ.size(), 0);

    // Reset in the middle of the payload clears outputs without a clock edge.
    doReset();
    preLen = 32'd0;
    burstLen = 32'd8;
    period = 32'd40;
    enable = 1'b1;
    pushBurst32(0, 8);
    repeat (4) stepCycle();
    #2;
    rst = 1'b1;
    #1;
    checkVal("async_tvalid", tvalid, 0);
    checkVal("async_tdata", tdata, 0);
    checkVal("async_tlast", tlast, 0);
    checkVal("async_tuser", tuser, 0);
    checkVal("async_tkeep", tkeep, 0);
    expQ.delete();
    startCycles.delete();
    prevStall = 1'b0;
    prevUserValid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    burstLen = 32'd1;
    expQ.push_back('{DEL32, 1'b1, 1'b0});
    expQ.push_back('{32'h0000000E, 1'b0, 1'b1});
    for (int c = 0; c < 50 && expQ.size() != 0; c++) begin
      stepCycle();
      if (startCycles.size() >= 1) enable = 1'b0;
    end
    checkVal("post_reset_drain", expQ.size(), 0);

    // 64-bit PRBS7 instance: two bursts, payload continuity or reseed.
    doReset();
    pushBurst64(1, 3);
    pushBurst64(1, 3);
    en64 = 1'b1;
    starts64 = 0;
    for (int c = 0; c < 200 && exp64.size() != 0; c++) begin
      @(negedge clk);
      if (tvalid64) checkVal("tkeep64", tkeep64, 8'hFF);
      if (tvalid64 && tready64) begin
        e64 = exp64.pop_front();
        checkVal("word64", {tdata64, tuser64, tlast64}, {e64.data, e64.user, e64.last});
        if (tuser64) starts64++;
      end
      @(posedge clk);
      #1;
      if (starts64 >= 2) en64 = 1'b0;
    end
    checkVal("drain64", exp64.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    checkVal("count64", burstCount64, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
